// File: rtl/conv_sequencer_if.sv
// Handshake and data bus between a convolution requester and conv_sequencer.
// Matrix buses use the unified 5x5 layout; kernels use the 3x3 layout.
interface conv_sequencer_if;
    logic         start;
    logic [2:0]   in_m;
    logic [2:0]   in_n;
    logic [1:0]   k_m;
    logic [1:0]   k_n;
    logic [399:0] matrices_in;
    logic [71:0]  kernelMatrix;
    logic         busy;
    logic         done;
    logic         valid;
    logic         err;
    logic [2:0]   out_m;
    logic [2:0]   out_n;
    logic [399:0] matrices_out;
    logic [9:0]   cycleCount;

    modport master (
        output start, in_m, in_n, k_m, k_n, matrices_in, kernelMatrix,
        input  busy, done, valid, err, out_m, out_n, matrices_out, cycleCount
    );

    modport slave (
        input  start, in_m, in_n, k_m, k_n, matrices_in, kernelMatrix,
        output busy, done, valid, err, out_m, out_n, matrices_out, cycleCount
    );
endinterface

// File: rtl/conv_sequencer.sv
// Sequential 2-D convolution: one shared 8x8 MAC stepped one kernel element per
// cycle through IDLE -> CHECK -> RUN -> DONE, with registered handshaked results.
module conv_sequencer #(
    parameter int DW    = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    conv_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       im_q, im_d, in_q, in_d;
    logic [1:0]       km_q, km_d, kn_q, kn_d;
    logic [199:0]     mat_q, mat_d;
    logic [71:0]      ker_q, ker_d;
    logic [2:0]       i_q, i_d, j_q, j_d;
    logic [1:0]       ki_q, ki_d, kj_q, kj_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       om_q, om_d, on_q, on_d;
    logic [199:0]     res_q, res_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Datapath: select the current input and kernel element and accumulate.
    logic [4:0]        row, col, eidx, oidx;
    logic [7:0]        ebit, obit;
    logic [3:0]        kidx;
    logic [6:0]        kbit;
    logic [DW-1:0]     elem, kel;
    logic [2*DW-1:0]   prod;
    logic [ACC_W-1:0]  sum;
    logic              illegal, last_k, last_j, last_i;

    assign row  = 5'(i_q) + 5'(ki_q);
    assign col  = 5'(j_q) + 5'(kj_q);
    assign eidx = row * 5'd5 + col;
    assign ebit = {eidx, 3'b000};
    assign kidx = 4'(ki_q) * 4'd3 + 4'(kj_q);
    assign kbit = {kidx, 3'b000};
    assign oidx = 5'(i_q) * 5'd5 + 5'(j_q);
    assign obit = {oidx, 3'b000};

    assign elem = mat_q[ebit +: DW];
    assign kel  = ker_q[kbit +: DW];
    assign prod = {{DW{1'b0}}, elem} * {{DW{1'b0}}, kel};
    assign sum  = acc_q + ACC_W'(prod);

    assign illegal = (im_q == 3'd0) || (in_q == 3'd0) || (km_q == 2'd0) || (kn_q == 2'd0) ||
                     (im_q > 3'd5) || (in_q > 3'd5) ||
                     (im_q < {1'b0, km_q}) || (in_q < {1'b0, kn_q});

    assign last_k = (kj_q == kn_q - 2'd1) && (ki_q == km_q - 2'd1);
    assign last_j = (j_q == on_q - 3'd1);
    assign last_i = (i_q == om_q - 3'd1);

    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        in_d    = in_q;
        km_d    = km_q;
        kn_d    = kn_q;
        mat_d   = mat_q;
        ker_d   = ker_q;
        i_d     = i_q;
        j_d     = j_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        acc_d   = acc_q;
        om_d    = om_q;
        on_d    = on_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    im_d    = bus.in_m;
                    in_d    = bus.in_n;
                    km_d    = bus.k_m;
                    kn_d    = bus.k_n;
                    mat_d   = bus.matrices_in[199:0];
                    ker_d   = bus.kernelMatrix;
                    res_d   = '0;
                    om_d    = 3'd0;
                    on_d    = 3'd0;
                    cnt_d   = 10'd0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    om_d    = im_q - {1'b0, km_q} + 3'd1;
                    on_d    = in_q - {1'b0, kn_q} + 3'd1;
                    i_d     = 3'd0;
                    j_d     = 3'd0;
                    ki_d    = 2'd0;
                    kj_d    = 2'd0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 10'd1;
                if (last_k) begin
                    res_d[obit +: 8] = sum[7:0];
                    acc_d = '0;
                    ki_d  = 2'd0;
                    kj_d  = 2'd0;
                    if (last_j) begin
                        j_d = 3'd0;
                        if (last_i) begin
                            i_d     = 3'd0;
                            // valid must already read 1 during the DONE cycle
                            valid_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + 3'd1;
                        end
                    end else begin
                        j_d = j_q + 3'd1;
                    end
                end else begin
                    acc_d = sum;
                    if (kj_q == kn_q - 2'd1) begin
                        kj_d = 2'd0;
                        ki_d = ki_q + 2'd1;
                    end else begin
                        kj_d = kj_q + 2'd1;
                    end
                end
            end
            default: begin
                valid_d = ~err_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            im_q    <= '0;
            in_q    <= '0;
            km_q    <= '0;
            kn_q    <= '0;
            mat_q   <= '0;
            ker_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ki_q    <= '0;
            kj_q    <= '0;
            acc_q   <= '0;
            om_q    <= '0;
            on_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            in_q    <= in_d;
            km_q    <= km_d;
            kn_q    <= kn_d;
            mat_q   <= mat_d;
            ker_q   <= ker_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ki_q    <= ki_d;
            kj_q    <= kj_d;
            acc_q   <= acc_d;
            om_q    <= om_d;
            on_q    <= on_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy         = (state_q == S_CHECK) || (state_q == S_RUN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.valid        = valid_q;
    assign bus.err          = err_q;
    assign bus.out_m        = om_q;
    assign bus.out_n        = on_q;
    assign bus.matrices_out = {200'd0, res_q};
    assign bus.cycleCount   = cnt_q;

    // Upper half of the unified bus carries nothing for a 5x5 operand.
    logic unused_hi;
    assign unused_hi = ^bus.matrices_in[399:200];
endmodule
